dm_port_arbiter: RTL

Two-requester arbiter that shares the single-port data memory between the CPU and an external requester (debug loader / I/O DMA). It sits between the CPU's data-memory bus (address, write data, MW) and the data memory's inAddress/inData/readWriteControl pins, and returns read data and a one-cycle acknowledge to whichever requester was served. Arbitration is round-robin by default. A lock input lets a requester hold the memory across several accesses, for example a read-modify-write.

---
 rtl/dm_port_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU and an external requester.
// Round-robin by default; define DM_ARB_CPU_PRIORITY_EN for fixed CPU priority in IDLE.
module dm_port_arbiter #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic                 cpu_lock,
    input  logic [BUS_WIDTH-1:0] cpu_addr,
    input  logic [BUS_WIDTH-1:0] cpu_wdata,
    output logic                 cpu_ack,
    output logic [BUS_WIDTH-1:0] cpu_rdata,
    input  logic                 ext_req,
    input  logic                 ext_we,
    input  logic                 ext_lock,
    input  logic [BUS_WIDTH-1:0] ext_addr,
    input  logic [BUS_WIDTH-1:0] ext_wdata,
    output logic                 ext_ack,
    output logic [BUS_WIDTH-1:0] ext_rdata,
    output logic [BUS_WIDTH-1:0] dm_addr,
    output logic [BUS_WIDTH-1:0] dm_wdata,
    output logic                 dm_mw,
    input  logic [BUS_WIDTH-1:0] dm_rdata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_ACC  = 3'd1,
        EXT_ACC  = 3'd2,
        CPU_LOCK = 3'd3,
        EXT_LOCK = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;   // 0 = CPU, 1 = EXT
    logic   cpu_wins;

`ifdef DM_ARB_CPU_PRIORITY_EN
    assign cpu_wins = cpu_req;
`else
    assign cpu_wins = cpu_req && (!ext_req || last_grant_q);
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (cpu_wins) begin
                    state_d      = CPU_ACC;
                    last_grant_d = 1'b0;
                end else if (ext_req) begin
                    state_d      = EXT_ACC;
                    last_grant_d = 1'b1;
                end
            end
            CPU_ACC:  state_d = cpu_lock ? CPU_LOCK : IDLE;
            EXT_ACC:  state_d = ext_lock ? EXT_LOCK : IDLE;
            CPU_LOCK: begin
                if (cpu_req)       state_d = CPU_ACC;
                else if (!cpu_lock) state_d = IDLE;
            end
            EXT_LOCK: begin
                if (ext_req)       state_d = EXT_ACC;
                else if (!ext_lock) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs decode the registered state so reset clears them without waiting for an edge.
    always_comb begin
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_mw     = 1'b0;
        cpu_ack   = 1'b0;
        cpu_rdata = '0;
        ext_ack   = 1'b0;
        ext_rdata = '0;
        case (state_q)
            CPU_ACC: begin
                dm_addr   = cpu_addr;
                dm_wdata  = cpu_wdata;
                dm_mw     = cpu_we;
                cpu_ack   = 1'b1;
                cpu_rdata = dm_rdata;
            end
            EXT_ACC: begin
                dm_addr   = ext_addr;
                dm_wdata  = ext_wdata;
                dm_mw     = ext_we;
                ext_ack   = 1'b1;
                ext_rdata = dm_rdata;
            end
            default: ;
        endcase
    end

endmodule
